vesa_line_fetch: RTL
====================

Name: vesa_line_fetch

Overview:
- Scanout fetch scheduler that sits beside the VESA timing generator.
- Uses the generator's registered vsync/data_en to issue burst read commands to the frame-buffer memory port, one display line ahead of the raster.
- Line 0 is prefetched during vertical blanking; line N+1 is requested when active video of line N ends.
- Flags underrun when the raster outruns the command stream.

Parameters:
- H_ACTIVE, 1280, active pixels per line
- V_ACTIVE, 720, active lines per frame
- BURST_PIXELS, 64, pixels per burst; H_ACTIVE must be an integer multiple
- LINE_STRIDE, 2048, address increment between lines (pixel units)
- ADDR_W, 24, memory address width

Ports:
- clock  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- vsync  in  1  from timing generator, registered, high during sync
- data_en  in  1  from timing generator, registered, high during active pixels
- enable  in  1  scheduler enable
- fb_base  in  ADDR_W  frame base address, shadowed at frame start
- cmd_valid  out  1  burst command valid
- cmd_ready  in  1  memory port accepts command
- cmd_addr  out  ADDR_W  burst start address
- cmd_len  out  8  burst length (constant BURST_PIXELS)
- cmd_last  out  1  high with the final burst of a line
- fetch_line  out  11  line index being requested
- fetch_busy  out  1  high in ISSUE state
- underrun  out  1  sticky error flag
- underrun_clr  in  1  clears underrun

Behaviour:
- Reset (async, all outputs): cmd_valid=0, cmd_addr=0, cmd_last=0, fetch_line=0, fetch_busy=0, underrun=0, state=IDLE.
- cmd_len is constant BURST_PIXELS.
- Edge detect: the block keeps registered copies vsync_d and de_d. No resynchronisation; the inputs are already registered in the same clock domain.
  - vs_rise = vsync & ~vsync_d
  - de_fall = ~data_en & de_d
  - de_rise = data_en & ~de_d
- Define BURSTS = H_ACTIVE / BURST_PIXELS.
- State IDLE:
  - Outputs idle.
  - enable=1 moves to WAIT_FRAME.
- State WAIT_FRAME, on vs_rise:
  - base_shadow <= fb_base; line_base <= fb_base
  - burst_idx=0, fetch_line=0
  - go to ISSUE
  - cmd_valid is high from the next cycle, i.e. one clock after vsync is first sampled high.
- State ISSUE:
  - cmd_valid=1.
  - cmd_addr = line_base + burst_idx*BURST_PIXELS, computed incrementally and wrapping mod 2^ADDR_W.
  - cmd_last = (burst_idx==BURSTS-1).
  - AXI-style handshake: cmd_addr and cmd_last stay stable while cmd_valid & ~cmd_ready. cmd_valid never drops without acceptance.
  - On acceptance (valid & ready), when not last: burst_idx++, and the next command is presented in the following cycle. Back-to-back acceptance gives one burst per clock.
  - On acceptance of the last burst: burst_idx=0, line_base += LINE_STRIDE, fetch_line++, go to WAIT_LINE. cmd_valid is low in the next cycle.
- State WAIT_LINE:
  - On de_fall with fetch_line==V_ACTIVE, go to WAIT_FRAME.
  - On de_fall otherwise, go to ISSUE.
  - On vs_rise, re-arm the frame exactly as in WAIT_FRAME. This is a defensive path.
- Underrun, set when either of these occurs:
  - de_rise while in ISSUE (line not fully requested). The current line continues being issued.
  - vs_rise while in ISSUE. Behaviour on this path:
    - If cmd_valid is low, or accepted that cycle: restart the frame immediately (shadow fb_base, fetch_line=0).
    - Otherwise hold the pending command until accepted, then restart.
- underrun_clr clears underrun. If a set event and clr occur in the same cycle, set wins.
- enable deasserted:
  - From WAIT_FRAME or WAIT_LINE: go to IDLE next cycle.
  - From ISSUE: finish the pending handshake, then go to IDLE. No further bursts are issued.
- enable asserted mid-frame: waits for the next vs_rise. No partial frame is fetched.
- fb_base changes mid-frame take effect only at the next vs_rise (tear-free).

Decomposition:
- Shared package vesa_pkg holds:
  - timing constants H_ACTIVE, V_ACTIVE and the porch/sync constants (shared with the timing generator)
  - the state enum fetch_state_t {IDLE, WAIT_FRAME, ISSUE, WAIT_LINE}
- One natural sub-module, vesa_edge_det: registered rise/fall detector, instanced for vsync and data_en.
- Address generation stays inline.

Test Plan:
All scenarios use H_ACTIVE=16, V_ACTIVE=4, BURST_PIXELS=8, LINE_STRIDE=32, ADDR_W=24, fb_base=0x100.
- Nominal frame, cmd_ready tied 1:
  - After vs_rise: cmd_addr 0x100 then 0x108 (cmd_last on 0x108).
  - After each de_fall: 0x120/0x128, 0x140/0x148, 0x160/0x168.
  - After the 4th de_fall: no commands until the next vs_rise. Exactly 8 commands per frame.
- Backpressure: cmd_ready low for 5 cycles on the first burst -> cmd_valid and cmd_addr=0x100 held stable for all 5 cycles. 0x108 appears the cycle after acceptance.
- Underrun: cmd_ready held low until after the next de_rise -> underrun=1 and stays set. underrun_clr pulse -> 0. Simultaneous set and clr -> 1.
- Base shadowing: fb_base changed to 0x400 mid-frame -> the remaining lines still use 0x1xx; the next frame starts at 0x400.
- Reset mid-ISSUE: reset asserted while cmd_valid=1 -> cmd_valid=0 immediately (asynchronous). After release with enable=1: nothing is issued until vs_rise, then 0x100.
- Disable mid-ISSUE with cmd_ready=0: enable=0 -> cmd_valid held until accepted, then IDLE. No further commands are issued.

Source files
------------

// File: rtl/vesa_pkg.sv
// Shared VESA raster constants and the line-fetch scheduler state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package vesa_pkg;

  // 1280x720@60 timing, shared with the timing generator
  localparam int H_ACTIVE = 1280;
  localparam int H_FRONT  = 110;
  localparam int H_SYNC   = 40;
  localparam int H_BACK   = 220;
  localparam int V_ACTIVE = 720;
  localparam int V_FRONT  = 5;
  localparam int V_SYNC   = 5;
  localparam int V_BACK   = 20;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_FRAME,
    ISSUE,
    WAIT_LINE
  } fetch_state_t;

endpackage

// File: rtl/vesa_edge_det.sv
// Registered rise/fall detector for an already-synchronous level signal.
// Latency: edge flags are combinational from the input, one register of history.
// Backpressure: none.
module vesa_edge_det (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic sig_q;

  // keep last cycle's level so edges are seen the cycle the input changes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sig_q <= 1'b0;
    else       sig_q <= sig_i;
  end

  assign rise_o = sig_i & ~sig_q;
  assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/vesa_line_fetch.sv
// Scanout fetch scheduler: issues burst reads one display line ahead of the raster.
// Latency: first command valid one clock after vsync rises; one burst per clock when ready.
// Backpressure: valid/ready; address and last held stable until the command is accepted.
module vesa_line_fetch #(
  parameter int H_ACTIVE     = vesa_pkg::H_ACTIVE,
  parameter int V_ACTIVE     = vesa_pkg::V_ACTIVE,
  parameter int BURST_PIXELS = 64,  // H_ACTIVE must be a multiple of this
  parameter int LINE_STRIDE  = 2048,
  parameter int ADDR_W       = 24
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              vsync_i,
  input  logic              data_en_i,
  input  logic              enable_i,
  input  logic [ADDR_W-1:0] fb_base_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [ADDR_W-1:0] cmd_addr_o,
  output logic [7:0]        cmd_len_o,
  output logic              cmd_last_o,
  output logic [10:0]       fetch_line_o,
  output logic              fetch_busy_o,
  output logic              underrun_o,
  input  logic              underrun_clr_i
);

  import vesa_pkg::*;

  localparam int BURSTS = H_ACTIVE / BURST_PIXELS;
  localparam int BIDX_W = (BURSTS > 1) ? $clog2(BURSTS) : 1;
  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BURSTS - 1);

  fetch_state_t      state_q, state_d;
  logic [BIDX_W-1:0] burst_idx_q, burst_idx_d;
  logic [ADDR_W-1:0] line_base_q, line_base_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [10:0]       fetch_line_q, fetch_line_d;
  logic              restart_q, restart_d;
  logic              underrun_q, underrun_d;

  logic vs_rise, vs_fall_unused, de_rise, de_fall;
  logic issuing, accept, last_burst, arm;

  vesa_edge_det u_vs_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (vsync_i),
    .rise_o (vs_rise),
    .fall_o (vs_fall_unused)
  );

  vesa_edge_det u_de_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .sig_i  (data_en_i),
    .rise_o (de_rise),
    .fall_o (de_fall)
  );

  assign issuing    = (state_q == ISSUE);
  assign accept     = issuing & cmd_ready_i;
  assign last_burst = (burst_idx_q == LAST_IDX);

  // next-state, address walk and frame re-arm
  always_comb begin
    state_d      = state_q;
    burst_idx_d  = burst_idx_q;
    line_base_d  = line_base_q;
    cmd_addr_d   = cmd_addr_q;
    fetch_line_d = fetch_line_q;
    restart_d    = restart_q;
    arm          = 1'b0;

    case (state_q)
      IDLE: begin
        if (enable_i) state_d = WAIT_FRAME;
      end
      WAIT_FRAME: begin
        if (!enable_i)    state_d = IDLE;
        else if (vs_rise) arm = 1'b1;
      end
      ISSUE: begin
        // a vsync that lands on a stalled command is remembered until it drains
        if (vs_rise && !accept) restart_d = 1'b1;
        if (accept) begin
          if (!enable_i) begin
            state_d   = IDLE;
            restart_d = 1'b0;
          end else if (vs_rise || restart_q) begin
            arm       = 1'b1;
            restart_d = 1'b0;
          end else if (last_burst) begin
            burst_idx_d  = '0;
            line_base_d  = line_base_q + ADDR_W'(LINE_STRIDE);
            cmd_addr_d   = line_base_q + ADDR_W'(LINE_STRIDE);
            fetch_line_d = fetch_line_q + 11'd1;
            state_d      = WAIT_LINE;
          end else begin
            burst_idx_d = burst_idx_q + BIDX_W'(1);
            cmd_addr_d  = cmd_addr_q + ADDR_W'(BURST_PIXELS);
          end
        end
      end
      WAIT_LINE: begin
        if (!enable_i)    state_d = IDLE;
        else if (vs_rise) arm = 1'b1;
        else if (de_fall) state_d = (fetch_line_q == 11'(V_ACTIVE)) ? WAIT_FRAME : ISSUE;
      end
      default: state_d = IDLE;
    endcase

    // frame start: fb_base is sampled only here so a mid-frame change cannot tear
    if (arm) begin
      line_base_d  = fb_base_i;
      cmd_addr_d   = fb_base_i;
      burst_idx_d  = '0;
      fetch_line_d = '0;
      state_d      = ISSUE;
    end
  end

  // sticky underrun: the raster entered a line or frame that is still being requested
  always_comb begin
    underrun_d = underrun_q & ~underrun_clr_i;
    if (issuing && (de_rise || vs_rise)) underrun_d = 1'b1;
  end

  // state and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      burst_idx_q  <= '0;
      line_base_q  <= '0;
      cmd_addr_q   <= '0;
      fetch_line_q <= '0;
      restart_q    <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      burst_idx_q  <= burst_idx_d;
      line_base_q  <= line_base_d;
      cmd_addr_q   <= cmd_addr_d;
      fetch_line_q <= fetch_line_d;
      restart_q    <= restart_d;
      underrun_q   <= underrun_d;
    end
  end

  assign cmd_valid_o  = issuing;
  assign fetch_busy_o = issuing;
  assign cmd_addr_o   = cmd_addr_q;
  assign cmd_last_o   = issuing & last_burst;
  assign cmd_len_o    = 8'(BURST_PIXELS);
  assign fetch_line_o = fetch_line_q;
  assign underrun_o   = underrun_q;

endmodule
